bcd_time_counter: RTL and testbench
===================================

Name: bcd_time_counter

Overview:
- Downstream consumer of the half-second toggling clock from the clock generator.
- Brings that slow clock into the s_clk domain with a synchroniser, rising-edge detects it (one event per second), and advances an HH:MM:SS BCD time-of-day counter.
- Outputs drive the 7-segment decoder stage.
- Supports run/pause and a validated parallel time load.

Parameters:
- MAX_HOUR, 23, last hour value before wrap to 00 (legal range 1..23).
- SYNC_STAGES, 2, synchroniser flop count on tick_clk (legal values 2 or 3).

Ports:
- s_clk  input  1  system clock (50 MHz); sole clock of the block
- rst_n  input  1  asynchronous active-low reset
- tick_clk  input  1  slow clock from the clock generator; treated as asynchronous data
- run  input  1  1 = count on each second event, 0 = hold
- load_en  input  1  single-cycle load strobe, s_clk domain
- load_time  input  24  {hh_t[3:0], hh_o, mm_t, mm_o, ss_t, ss_o}, each field 4-bit BCD
- hh  output  8  hours BCD {tens, ones}
- mm  output  8  minutes BCD
- ss  output  8  seconds BCD
- sec_pulse  output  1  one s_clk pulse on each detected tick_clk rising edge
- day_wrap  output  1  one s_clk pulse when the time rolls from MAX_HOUR:59:59 to 00:00:00
- load_err  output  1  one s_clk pulse when a load is rejected

Behaviour:
- Reset (async, rst_n=0):
  - hh=mm=ss=8'h00; sec_pulse=day_wrap=load_err=0.
  - Synchroniser flops and edge register cleared to 0.
  - rst_n is the clear-on-reset for every flop in the block.
- Synchronisation and edge detection:
  - tick_clk passes through SYNC_STAGES flops, then one delay flop.
  - sec_pulse = registered (sync_out & ~delayed).
  - A tick_clk rise sampled at s_clk edge N gives sec_pulse=1 during cycle N+SYNC_STAGES+1, for exactly 1 cycle.
  - A falling edge produces no event.
  - sec_pulse is generated regardless of run.
  - After reset release with tick_clk already high, the first rise is detected, since the synchroniser clears to 0.
- Counting: on a cycle with sec_pulse=1 and run=1, the time increments; registered outputs update on the next s_clk edge. Cascade:
  - ss_o 9 -> 0 carries into ss_t; ss_t 5 with ss_o 9 -> ss=00 and carries into minutes.
  - Minutes use the same 59 rule and carry into hours.
  - Hours: at hh == BCD(MAX_HOUR) with a carry, hh -> 00. Otherwise hh_o 9 -> 0 with tens+1.
  - day_wrap pulses on the same edge the outputs go to 00:00:00.
- Pause: run=0 holds all counters; the second events are lost, not queued.
- Load, when load_en=1:
  - Validation: each ones digit <=9; ss_t<=5; mm_t<=5; the hour value (tens*10+ones) <= MAX_HOUR with hh_o<=9.
  - Valid: hh/mm/ss take load_time on the next edge.
  - Invalid: counters unchanged and load_err pulses for 1 cycle.
  - Load is accepted independent of run.
- Simultaneous events:
  - load_en together with a counting sec_pulse: load wins and that second is dropped; no day_wrap.
  - Rejected load together with a counting sec_pulse: the increment proceeds normally.
- Reset mid-operation: immediate async clear of all state; no pulse outputs are asserted during or after reset until a new event.
- Arithmetic: per-digit 4-bit BCD with explicit compare-and-wrap. Binary addition followed by conversion is not permitted. Outputs never hold non-BCD codes.

Test Plan:
- Reset: hold rst_n=0 with tick_clk toggling -> hh/mm/ss=00:00:00, no sec_pulse. Release with run=1, drive a tick_clk rise -> sec_pulse exactly SYNC_STAGES+1 cycles after the sampled rise, then ss=8'h01.
- Cascade: load 23:59:58, run=1, two rises -> 23:59:59, then 00:00:00 with a single day_wrap pulse. Load 09:59:59 plus one rise -> 10:00:00, no day_wrap.
- Invalid loads: load_time 24:00:00, 12:60:00, 12:0A:00 -> each gives one load_err pulse and the prior time is unchanged. 00:00:00 and 23:59:59 are accepted.
- Pause: run=0 across 3 tick_clk rises -> 3 sec_pulse pulses and time frozen. run=1 afterwards -> the next rise advances by exactly 1 s.
- Collision: load 05:05:05 in the same cycle as a counting sec_pulse -> result 05:05:05, not 05:05:06. Invalid load in the same cycle as a counting sec_pulse -> time increments and load_err=1.
- Parameter/glitch: MAX_HOUR=11, load 11:59:59 plus one rise -> 00:00:00 with day_wrap. A tick_clk glitch shorter than one s_clk period produces at most one sec_pulse.

Source files
------------

// File: rtl/bcd_time_counter.sv
// HH:MM:SS BCD time-of-day counter advanced by a synchronised, edge-detected slow tick.
// Supports run/pause, a validated parallel load, and pulses for second, day wrap and load reject.
module bcd_time_counter #(
    parameter int MAX_HOUR    = 23,
    parameter int SYNC_STAGES = 2
) (
    input  logic        s_clk,
    input  logic        rst_n,
    input  logic        tick_clk,
    input  logic        run,
    input  logic        load_en,
    input  logic [23:0] load_time,
    output logic [7:0]  hh,
    output logic [7:0]  mm,
    output logic [7:0]  ss,
    output logic        sec_pulse,
    output logic        day_wrap,
    output logic        load_err
);
    localparam logic [3:0] MAX_HT = 4'(MAX_HOUR / 10);
    localparam logic [3:0] MAX_HO = 4'(MAX_HOUR % 10);
    localparam logic [7:0] MAX_HH = {MAX_HT, MAX_HO};

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   delayed;
    logic                   sync_out;

    assign sync_out = sync_q[SYNC_STAGES-1];

    // NOTE: the synchroniser clears to 0, so a tick_clk already high at reset release reads as a rise.
    always_ff @(posedge s_clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q    <= '0;
            delayed   <= 1'b0;
            sec_pulse <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], tick_clk};
            delayed   <= sync_out;
            sec_pulse <= sync_out & ~delayed;
        end
    end

    // Two-digit BCD increment with wrap after 59.
    function automatic logic [7:0] inc59(input logic [7:0] v);
        if (v[3:0] == 4'd9)
            return (v[7:4] == 4'd5) ? 8'h00 : {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    logic       ss_last;
    logic       mm_last;
    logic       hh_last;
    logic [7:0] hh_inc;
    logic       load_valid;

    assign ss_last = (ss == 8'h59);
    assign mm_last = (mm == 8'h59);
    assign hh_last = (hh == MAX_HH);
    assign hh_inc  = hh_last            ? 8'h00 :
                     (hh[3:0] == 4'd9)  ? {hh[7:4] + 4'd1, 4'd0} :
                                          {hh[7:4], hh[3:0] + 4'd1};

    assign load_valid = (load_time[3:0]   <= 4'd9) &&
                        (load_time[7:4]   <= 4'd5) &&
                        (load_time[11:8]  <= 4'd9) &&
                        (load_time[15:12] <= 4'd5) &&
                        (load_time[19:16] <= 4'd9) &&
                        ((load_time[23:20] < MAX_HT) ||
                         ((load_time[23:20] == MAX_HT) && (load_time[19:16] <= MAX_HO)));

    // NOTE: pulse outputs default low each cycle and are raised only by the branch that owns the event.
    always_ff @(posedge s_clk or negedge rst_n) begin
        if (!rst_n) begin
            hh       <= 8'h00;
            mm       <= 8'h00;
            ss       <= 8'h00;
            day_wrap <= 1'b0;
            load_err <= 1'b0;
        end else begin
            day_wrap <= 1'b0;
            load_err <= 1'b0;
            if (load_en && load_valid) begin
                // An accepted load takes priority and drops any coincident second.
                hh <= load_time[23:16];
                mm <= load_time[15:8];
                ss <= load_time[7:0];
            end else begin
                load_err <= load_en;
                if (sec_pulse && run) begin
                    ss <= inc59(ss);
                    if (ss_last) begin
                        mm <= inc59(mm);
                        if (mm_last) begin
                            hh       <= hh_inc;
                            day_wrap <= hh_last;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_bcd_time_counter.sv
// Self-checking bench: cycle model in seconds-of-day for the default build, plus a MAX_HOUR=11,
// SYNC_STAGES=3 instance exercised by a short hand-written sequence.
module tb_bcd_time_counter;
    localparam int S   = 2;
    localparam int S11 = 3;
    localparam int DAY = 24 * 3600;

    logic        s_clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tick_clk = 1'b0, run = 1'b0, load_en = 1'b0;
    logic [23:0] load_time = '0;
    logic [7:0]  hh, mm, ss;
    logic        sec_pulse, day_wrap, load_err;

    logic        tick_b = 1'b0, run_b = 1'b0, load_en_b = 1'b0;
    logic [23:0] load_time_b = '0;
    logic [7:0]  hh_b, mm_b, ss_b;
    logic        sec_pulse_b, day_wrap_b, load_err_b;

    bcd_time_counter #(.MAX_HOUR(23), .SYNC_STAGES(S)) dut (
        .s_clk(s_clk), .rst_n(rst_n), .tick_clk(tick_clk), .run(run), .load_en(load_en),
        .load_time(load_time), .hh(hh), .mm(mm), .ss(ss), .sec_pulse(sec_pulse),
        .day_wrap(day_wrap), .load_err(load_err)
    );

    bcd_time_counter #(.MAX_HOUR(11), .SYNC_STAGES(S11)) dut11 (
        .s_clk(s_clk), .rst_n(rst_n), .tick_clk(tick_b), .run(run_b), .load_en(load_en_b),
        .load_time(load_time_b), .hh(hh_b), .mm(mm_b), .ss(ss_b), .sec_pulse(sec_pulse_b),
        .day_wrap(day_wrap_b), .load_err(load_err_b)
    );

    always #5 s_clk = ~s_clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int sp_cnt = 0, dw_cnt = 0, sp_b_cnt = 0, dw_b_cnt = 0;

    // Reference model: time as seconds of the day, tick history as sampled at each s_clk edge.
    int m_t;
    bit m_pulse, m_dw, m_le;
    bit hist[$];

    typedef struct {
        logic [23:0] lt;
        bit          err;
    } load_vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [23:0] sec_to_bcd(input int t);
        int h, m, s;
        h = t / 3600;
        m = (t / 60) % 60;
        s = t % 60;
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    function automatic int bcd_to_sec(input logic [23:0] v);
        return (int'(v[23:20]) * 10 + int'(v[19:16])) * 3600 +
               (int'(v[15:12]) * 10 + int'(v[11:8])) * 60 +
               (int'(v[7:4]) * 10 + int'(v[3:0]));
    endfunction

    function automatic bit load_ok(input logic [23:0] v, input int max_h);
        int ht, ho, mt, mo, st, so;
        ht = int'(v[23:20]); ho = int'(v[19:16]);
        mt = int'(v[15:12]); mo = int'(v[11:8]);
        st = int'(v[7:4]);   so = int'(v[3:0]);
        return (ho <= 9) && (mo <= 9) && (so <= 9) && (mt <= 5) && (st <= 5) &&
               (ht * 10 + ho <= max_h);
    endfunction

    task automatic model_reset();
        m_t = 0; m_pulse = 0; m_dw = 0; m_le = 0;
        hist.delete();
        for (int i = 0; i <= S; i++) hist.push_back(1'b0);
    endtask

    // One s_clk cycle: advance the model from pre-edge inputs, then compare 1 time unit later.
    task automatic step();
        bit p;
        @(posedge s_clk);
        cyc++;
        p = m_pulse;
        hist.push_back(tick_clk);
        m_pulse = hist[hist.size() - 1 - S] && !hist[hist.size() - 2 - S];
        void'(hist.pop_front());
        m_dw = 0;
        m_le = 0;
        if (load_en && load_ok(load_time, 23)) begin
            m_t = bcd_to_sec(load_time);
        end else begin
            m_le = load_en;
            if (p && run) begin
                m_t  = (m_t + 1) % DAY;
                m_dw = (m_t == 0);
            end
        end
        #1;
        check("time", {8'h00, hh, mm, ss}, {8'h00, sec_to_bcd(m_t)});
        check("sec_pulse", 32'(sec_pulse), 32'(m_pulse));
        check("day_wrap", 32'(day_wrap), 32'(m_dw));
        check("load_err", 32'(load_err), 32'(m_le));
        if (sec_pulse)   sp_cnt++;
        if (day_wrap)    dw_cnt++;
        if (sec_pulse_b) sp_b_cnt++;
        if (day_wrap_b)  dw_b_cnt++;
    endtask

    task automatic pulse_tick();
        tick_clk = 1'b1;
        repeat (S + 3) step();
        tick_clk = 1'b0;
        repeat (3) step();
    endtask

    task automatic load(input logic [23:0] v);
        load_en = 1'b1; load_time = v;
        step();
        load_en = 1'b0;
    endtask

    task automatic do_reset(input bit tick_at_release);
        #2 rst_n = 1'b0;
        #1;
        check("rst_time", {8'h00, hh, mm, ss}, 32'h0);
        check("rst_time11", {8'h00, hh_b, mm_b, ss_b}, 32'h0);
        check("rst_pulses", {29'd0, sec_pulse, day_wrap, load_err}, 32'h0);
        repeat (4) begin
            @(posedge s_clk);
            #1;
            tick_clk = ~tick_clk;
            tick_b   = ~tick_b;
            check("rst_hold_time", {8'h00, hh, mm, ss}, 32'h0);
            check("rst_hold_pulse", {30'd0, sec_pulse, sec_pulse_b}, 32'h0);
        end
        tick_clk = tick_at_release;
        tick_b   = 1'b0;
        load_en  = 1'b0;
        model_reset();
        rst_n = 1'b1;
    endtask

    load_vec_t vecs[10];

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit found;
        logic [23:0] cur;
        int pre;

        // Reset with tick_clk toggling, then first-second latency and count.
        model_reset();
        run = 1'b1;
        repeat (4) begin
            @(posedge s_clk);
            #1;
            tick_clk = ~tick_clk;
            check("por_time", {8'h00, hh, mm, ss}, 32'h0);
            check("por_pulse", 32'(sec_pulse), 32'h0);
        end
        tick_clk = 1'b0;
        rst_n = 1'b1;
        step();
        tick_clk = 1'b1;
        n = 0; found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            step();
            n++;
            if (sec_pulse) found = 1;
        end
        check("sec_pulse_latency", 32'(n), 32'(S + 1));
        step();
        check("first_second", 32'(ss), 32'h01);
        tick_clk = 1'b0;
        repeat (3) step();

        // Load validation table, counters idle.
        run = 1'b0;
        vecs[0] = '{24'h240000, 1'b1};
        vecs[1] = '{24'h126000, 1'b1};
        vecs[2] = '{24'h120A00, 1'b1};
        vecs[3] = '{24'h000000, 1'b0};
        vecs[4] = '{24'h235959, 1'b0};
        vecs[5] = '{24'h0A0000, 1'b1};
        vecs[6] = '{24'h00005A, 1'b1};
        vecs[7] = '{24'h000060, 1'b1};
        vecs[8] = '{24'h195959, 1'b0};
        vecs[9] = '{24'h300000, 1'b1};
        cur = 24'h000001;
        foreach (vecs[i]) begin
            load(vecs[i].lt);
            if (!vecs[i].err) cur = vecs[i].lt;
            check("tbl_err", 32'(load_err), 32'(vecs[i].err));
            check("tbl_time", {8'h00, hh, mm, ss}, {8'h00, cur});
            step();
        end

        // Cascade through midnight and 09:59:59 -> 10:00:00.
        run = 1'b1;
        load(24'h235958);
        dw_cnt = 0;
        pulse_tick();
        check("pre_midnight", {8'h00, hh, mm, ss}, 32'h235959);
        pulse_tick();
        check("midnight", {8'h00, hh, mm, ss}, 32'h000000);
        check("midnight_wraps", 32'(dw_cnt), 32'd1);
        load(24'h095959);
        dw_cnt = 0;
        pulse_tick();
        check("hour_carry", {8'h00, hh, mm, ss}, 32'h100000);
        check("hour_carry_wraps", 32'(dw_cnt), 32'd0);

        // Pause loses seconds; resume advances by one.
        load(24'h123456);
        run = 1'b0;
        sp_cnt = 0;
        repeat (3) pulse_tick();
        check("pause_pulses", 32'(sp_cnt), 32'd3);
        check("pause_time", {8'h00, hh, mm, ss}, 32'h123456);
        run = 1'b1;
        pulse_tick();
        check("resume_time", {8'h00, hh, mm, ss}, 32'h123457);

        // Valid load coincident with a counting second: load wins.
        tick_clk = 1'b1;
        for (int i = 0; i < 10 && !m_pulse; i++) step();
        load(24'h050505);
        check("collide_load", {8'h00, hh, mm, ss}, 32'h050505);
        check("collide_load_wrap", 32'(day_wrap), 32'h0);
        tick_clk = 1'b0;
        repeat (4) step();

        // Invalid load coincident with a counting second: increment proceeds.
        pre = m_t;
        tick_clk = 1'b1;
        for (int i = 0; i < 10 && !m_pulse; i++) step();
        load(24'h246000);
        check("collide_bad_time", {8'h00, hh, mm, ss}, 32'h050506);
        check("collide_bad_err", 32'(load_err), 32'h1);
        check("collide_bad_model", 32'(m_t), 32'(pre + 1));
        tick_clk = 1'b0;
        repeat (4) step();

        // Glitches: one not spanning an edge, one spanning a single edge.
        sp_cnt = 0;
        #2 tick_clk = 1'b1;
        #3 tick_clk = 1'b0;
        repeat (6) step();
        check("glitch_unsampled", 32'(sp_cnt), 32'd0);
        #6 tick_clk = 1'b1;
        step();
        tick_clk = 1'b0;
        repeat (6) step();
        check("glitch_single", 32'(sp_cnt <= 1), 32'd1);

        // MAX_HOUR=11, SYNC_STAGES=3 instance.
        load_en_b = 1'b1; load_time_b = 24'h120000;
        step();
        load_en_b = 1'b0;
        check("p11_reject_err", 32'(load_err_b), 32'h1);
        check("p11_reject_time", {8'h00, hh_b, mm_b, ss_b}, 32'h000000);
        load_en_b = 1'b1; load_time_b = 24'h115959;
        step();
        load_en_b = 1'b0;
        check("p11_load", {8'h00, hh_b, mm_b, ss_b}, 32'h115959);
        run_b = 1'b1;
        dw_b_cnt = 0;
        tick_b = 1'b1;
        n = 0; found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            step();
            n++;
            if (sec_pulse_b) found = 1;
        end
        check("p11_latency", 32'(n), 32'(S11 + 1));
        step();
        check("p11_wrap_time", {8'h00, hh_b, mm_b, ss_b}, 32'h000000);
        check("p11_wrap_pulse", 32'(dw_b_cnt), 32'd1);
        tick_b = 1'b0;
        repeat (3) step();

        // Mid-operation reset, released with tick_clk already high.
        do_reset(1'b1);
        repeat (S + 3) step();
        check("post_reset_first", {8'h00, hh, mm, ss}, 32'h000001);
        tick_clk = 1'b0;
        repeat (3) step();

        // Randomised traffic against the model.
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 2) == 0) tick_clk = ~tick_clk;
            run = ($urandom_range(0, 3) != 0);
            load_en = ($urandom_range(0, 25) == 0);
            case ($urandom_range(0, 2))
                0:       load_time = sec_to_bcd($urandom_range(0, DAY - 1));
                1:       load_time = sec_to_bcd(DAY - 1 - $urandom_range(0, 2));
                default: load_time = 24'($urandom);
            endcase
            step();
        end
        load_en = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
